// File: rtl/mips_pkg.sv
// Shared definitions for the 5-stage MIPS pipeline control:
// opcodes, hazard FSM states and control-bundle bit positions.
package mips_pkg;

  localparam logic [5:0] RTYPE = 6'b000000;
  localparam logic [5:0] LW    = 6'b100011;
  localparam logic [5:0] SW    = 6'b101011;
  localparam logic [5:0] BEQ   = 6'b000100;
  localparam logic [5:0] NOP   = 6'b100000;

  localparam int M_BRANCH   = 2;
  localparam int M_MEMREAD  = 1;
  localparam int M_MEMWRITE = 0;

  typedef enum logic [1:0] {
    RUN,
    LD_STALL,
    MEM_WAIT,
    BR_FLUSH
  } hz_state_t;

  // One of the five opcodes the decoder understands.
  function automatic logic op_legal(input logic [5:0] op);
    logic r;
    r = 1'b0;
    case (op)
      RTYPE, LW, SW, BEQ, NOP: r = 1'b1;
      default:                 r = 1'b0;
    endcase
    return r;
  endfunction

  // Opcodes that read rt as a source operand.
  function automatic logic op_reads_rt(input logic [5:0] op);
    logic r;
    r = 1'b0;
    case (op)
      RTYPE, SW, BEQ: r = 1'b1;
      default:        r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use comparator: a load in ID/EX whose destination
// is a source of the instruction sitting in IF/ID.
module load_use_detect
  import mips_pkg::*;
(
  input  logic [5:0] id_opcode_i,
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  input  logic       idex_memread_i,
  input  logic [4:0] idex_rt_i,
  output logic       hazard_o
);

  logic rs_hit;
  logic rt_hit;

  // $0 is never a real dependency; rt only counts when it is read.
  always_comb begin
    rs_hit   = (idex_rt_i == id_rs_i);
    rt_hit   = (idex_rt_i == id_rt_i) & op_reads_rt(id_opcode_i);
    hazard_o = idex_memread_i & (idex_rt_i != 5'd0)
             & (rs_hit | rt_hit);
  end

endmodule

// File: rtl/hazard_sequencer.sv
// Hazard/stall sequencer for the 5-stage MIPS pipeline.
// Optional counters: define HAZARD_PERF_CNT_EN.
module hazard_sequencer
  import mips_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] id_opcode,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       idex_memread,
  input  logic [4:0] idex_rt,
  input  logic       exmem_branch,
  input  logic       exmem_zero,
  input  logic       exmem_memread,
  input  logic       exmem_memwrite,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_src,
  output logic       ifid_write,
  output logic       ifid_flush,
  output logic       idex_bubble,
  output logic       exmem_hold,
  output logic       exmem_flush,
  output logic       illegal_op,
  output logic       mem_err
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] ld_stall_cnt,
  output logic [CNT_W-1:0] br_flush_cnt,
  output logic [CNT_W-1:0] mem_wait_cnt
`endif
);

  localparam int TW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO = TW'(MEM_TIMEOUT);

  if (MEM_TIMEOUT < 2 || CNT_W < 1) begin : g_bad_param
    $error("hazard_sequencer: bad MEM_TIMEOUT/CNT_W");
  end

  hz_state_t     state_q, state_d;
  logic [TW-1:0] wait_q, wait_d;
  logic          ill_q, ill_d;
  logic          err_q, err_d;

  logic [2:0] exm;
  logic       mem_req;
  logic       hold;
  logic       br_take;
  logic       lu_raw;
  logic       lu_stall;

  load_use_detect u_lud (
    .id_opcode_i    (id_opcode),
    .id_rs_i        (id_rs),
    .id_rt_i        (id_rt),
    .idex_memread_i (idex_memread),
    .idex_rt_i      (idex_rt),
    .hazard_o       (lu_raw)
  );

  // Hazard classification in priority order.
  always_comb begin
    exm             = '0;
    exm[M_BRANCH]   = exmem_branch;
    exm[M_MEMREAD]  = exmem_memread;
    exm[M_MEMWRITE] = exmem_memwrite;
    mem_req  = exm[M_MEMREAD] | exm[M_MEMWRITE];
    hold     = mem_req & ~mem_ready;
    br_take  = exm[M_BRANCH] & exmem_zero & ~hold;
    lu_stall = lu_raw & ~hold & ~br_take
             & (state_q != LD_STALL)
             & (state_q != BR_FLUSH);
  end

  // Pipeline control outputs and next state.
  always_comb begin
    pc_write    = 1'b1;
    pc_src      = 1'b0;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    exmem_hold  = 1'b0;
    exmem_flush = 1'b0;
    state_d     = RUN;
    unique case (1'b1)
      hold: begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        exmem_hold = 1'b1;
        state_d    = MEM_WAIT;
      end
      br_take: begin
        pc_src      = 1'b1;
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        exmem_flush = 1'b1;
        state_d     = BR_FLUSH;
      end
      lu_stall: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
        state_d     = LD_STALL;
      end
      default: begin
        state_d = RUN;
      end
    endcase
    if (!hold && ill_q) begin
      idex_bubble = 1'b1;
    end
    ill_d = ifid_write & ~op_legal(id_opcode);
    if (!rst_n) begin
      pc_write    = 1'b0;
      pc_src      = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b1;
      exmem_hold  = 1'b0;
      exmem_flush = 1'b0;
    end
  end

  // Memory wait counter saturates at the timeout value.
  always_comb begin
    wait_d = '0;
    if (hold) begin
      wait_d = (wait_q == TMO) ? wait_q : wait_q + 1'b1;
    end
    err_d = err_q | (hold & (wait_d == TMO));
  end

  assign illegal_op = ill_q;
  assign mem_err    = err_q;

  // State, timeout counter and registered flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      wait_q  <= '0;
      ill_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      ill_q   <= ill_d;
      err_q   <= err_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] ld_q, br_q, mw_q;

  // Saturating event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_q <= '0;
      br_q <= '0;
      mw_q <= '0;
    end else begin
      if (lu_stall && !(&ld_q)) ld_q <= ld_q + 1'b1;
      if (br_take && !(&br_q))  br_q <= br_q + 1'b1;
      if (hold && !(&mw_q))     mw_q <= mw_q + 1'b1;
    end
  end

  assign ld_stall_cnt = ld_q;
  assign br_flush_cnt = br_q;
  assign mem_wait_cnt = mw_q;
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed vector bench for hazard_sequencer.
// Output vector order: pcw,pcs,ifw,iff,bub,hold,exf,ill,err.
module tb_hazard_sequencer;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_NOP = 6'b100000;
  localparam logic [5:0] OP_BAD = 6'b111111;

  localparam logic [8:0] E_RUN  = 9'b101000000;
  localparam logic [8:0] E_LU   = 9'b000010000;
  localparam logic [8:0] E_BR   = 9'b111110100;
  localparam logic [8:0] E_HOLD = 9'b000001000;
  localparam logic [8:0] E_ILL  = 9'b101010010;
  localparam logic [8:0] E_RST  = 9'b000010000;

  typedef struct {
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       idmr;
    logic [4:0] idrt;
    logic       br;
    logic       zr;
    logic       mr;
    logic       mw;
    logic       rdy;
    logic [8:0] exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] id_opcode;
  logic [4:0] id_rs, id_rt, idex_rt;
  logic       idex_memread;
  logic       exmem_branch, exmem_zero;
  logic       exmem_memread, exmem_memwrite, mem_ready;
  logic       pc_write, pc_src, ifid_write, ifid_flush;
  logic       idex_bubble, exmem_hold, exmem_flush;
  logic       illegal_op, mem_err;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] ld_stall_cnt, br_flush_cnt, mem_wait_cnt;
`endif

  int n_vec = 0;
  int n_bad = 0;
  vec_t tv[$];

  always #5 clk = ~clk;

  hazard_sequencer #(.MEM_TIMEOUT(16), .CNT_W(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_opcode      (id_opcode),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .idex_memread   (idex_memread),
    .idex_rt        (idex_rt),
    .exmem_branch   (exmem_branch),
    .exmem_zero     (exmem_zero),
    .exmem_memread  (exmem_memread),
    .exmem_memwrite (exmem_memwrite),
    .mem_ready      (mem_ready),
    .pc_write       (pc_write),
    .pc_src         (pc_src),
    .ifid_write     (ifid_write),
    .ifid_flush     (ifid_flush),
    .idex_bubble    (idex_bubble),
    .exmem_hold     (exmem_hold),
    .exmem_flush    (exmem_flush),
    .illegal_op     (illegal_op),
    .mem_err        (mem_err)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .ld_stall_cnt   (ld_stall_cnt),
    .br_flush_cnt   (br_flush_cnt),
    .mem_wait_cnt   (mem_wait_cnt)
`endif
  );

  function automatic vec_t mk(
    input logic [5:0] op, input logic [4:0] rs,
    input logic [4:0] rt, input logic idmr,
    input logic [4:0] idrt, input logic br,
    input logic zr, input logic mr, input logic mw,
    input logic rdy, input logic [8:0] exp);
    vec_t v;
    v.op = op; v.rs = rs; v.rt = rt;
    v.idmr = idmr; v.idrt = idrt;
    v.br = br; v.zr = zr; v.mr = mr; v.mw = mw;
    v.rdy = rdy; v.exp = exp;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    id_opcode      = v.op;
    id_rs          = v.rs;
    id_rt          = v.rt;
    idex_memread   = v.idmr;
    idex_rt        = v.idrt;
    exmem_branch   = v.br;
    exmem_zero     = v.zr;
    exmem_memread  = v.mr;
    exmem_memwrite = v.mw;
    mem_ready      = v.rdy;
  endtask

  task automatic check(input string nm, input logic [8:0] exp);
    logic [8:0] got;
    got = {pc_write, pc_src, ifid_write, ifid_flush,
           idex_bubble, exmem_hold, exmem_flush,
           illegal_op, mem_err};
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", nm, got, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t idle;
    idle = mk(OP_R, 1, 3, 0, 0, 0, 0, 0, 0, 1, E_RUN);
    tv.push_back(idle);
    tv.push_back(mk(OP_R, 2, 3, 1, 2, 0, 0, 0, 0, 1, E_LU));
    tv.push_back(mk(OP_R, 2, 3, 1, 2, 0, 0, 0, 0, 1, E_RUN));
    tv.push_back(mk(OP_R, 0, 3, 1, 0, 0, 0, 0, 0, 1, E_RUN));
    tv.push_back(mk(OP_R, 5, 7, 1, 7, 0, 0, 0, 0, 1, E_LU));
    tv.push_back(idle);
    tv.push_back(mk(OP_LW, 5, 7, 1, 7, 0, 0, 0, 0, 1, E_RUN));
    tv.push_back(mk(OP_SW, 5, 7, 1, 7, 0, 0, 0, 0, 1, E_LU));
    tv.push_back(idle);
    tv.push_back(mk(OP_R, 2, 3, 1, 2, 1, 1, 0, 0, 1, E_BR));
    tv.push_back(mk(OP_R, 2, 3, 1, 2, 0, 0, 0, 0, 1, E_RUN));
    tv.push_back(mk(OP_R, 1, 3, 0, 0, 1, 0, 0, 0, 1, E_RUN));
    tv.push_back(mk(OP_SW, 1, 3, 0, 0, 0, 0, 0, 1, 0, E_HOLD));
    tv.push_back(mk(OP_SW, 1, 3, 0, 0, 0, 0, 0, 1, 0, E_HOLD));
    tv.push_back(mk(OP_SW, 1, 3, 0, 0, 0, 0, 0, 1, 0, E_HOLD));
    tv.push_back(mk(OP_SW, 1, 3, 0, 0, 0, 0, 0, 1, 1, E_RUN));
    tv.push_back(mk(OP_R, 1, 3, 0, 0, 1, 1, 1, 0, 0, E_HOLD));
    tv.push_back(mk(OP_R, 1, 3, 0, 0, 1, 1, 1, 0, 1, E_BR));
    tv.push_back(idle);
    tv.push_back(mk(OP_BAD, 1, 3, 0, 0, 0, 0, 0, 0, 1, E_RUN));
    tv.push_back(mk(OP_R, 1, 3, 0, 0, 0, 0, 0, 0, 1, E_ILL));
    tv.push_back(idle);
    tv.push_back(mk(OP_BAD, 1, 3, 0, 0, 0, 0, 1, 0, 0, E_HOLD));
    tv.push_back(mk(OP_R, 1, 3, 0, 0, 0, 0, 1, 0, 1, E_RUN));
    tv.push_back(mk(OP_NOP, 1, 3, 0, 0, 0, 0, 0, 0, 1, E_RUN));
    tv.push_back(idle);
    tv.push_back(mk(OP_BEQ, 9, 4, 1, 4, 0, 0, 0, 0, 1, E_LU));
    tv.push_back(idle);

    rst_n = 1'b0;
    drive(idle);
    #2;
    check("reset_state", E_RST);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tv[i]) begin
      @(negedge clk);
      drive(tv[i]);
      #2;
      check($sformatf("vec%0d", i), tv[i].exp);
    end

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(mk(OP_R, 1, 3, 0, 0, 0, 0, 0, 1, 0, E_HOLD));
      #2;
      check($sformatf("tmo_wait%0d", i),
            E_HOLD | ((i >= 16) ? 9'b1 : 9'b0));
    end
    @(negedge clk);
    drive(mk(OP_R, 1, 3, 0, 0, 0, 0, 0, 1, 1, E_RUN));
    #2;
    check("tmo_done", E_RUN | 9'b1);
    @(negedge clk);
    drive(idle);
    #2;
    check("tmo_sticky", E_RUN | 9'b1);

    @(negedge clk);
    drive(mk(OP_R, 1, 3, 0, 0, 0, 0, 1, 0, 0, E_HOLD));
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_mid_wait", E_RST);
`ifdef HAZARD_PERF_CNT_EN
    n_vec++;
    if ({ld_stall_cnt, br_flush_cnt, mem_wait_cnt} !== 48'd0) begin
      n_bad++;
      $display("FAIL perf_rst: got %h %h %h expected 0",
               ld_stall_cnt, br_flush_cnt, mem_wait_cnt);
    end
`endif
    @(negedge clk);
    drive(idle);
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    check("post_rst_run", E_RUN);
    @(negedge clk);
    drive(mk(OP_R, 6, 3, 1, 6, 0, 0, 0, 0, 1, E_LU));
    #2;
    check("post_rst_lu", E_LU);
    @(negedge clk);
    drive(idle);
    #2;
    check("post_rst_idle", E_RUN);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
